// File: rtl/conv_pkg.sv
// conv_pkg: accelerator register map, weight count and conv_dma state encoding
package conv_pkg;
  localparam logic [3:0] ADDR_PIX = 4'd0;
  localparam logic [3:0] ADDR_RES = 4'd1;
  localparam logic [3:0] ADDR_CLR = 4'd2;
  localparam logic [3:0] ADDR_W0 = 4'd3;
  localparam int NUM_W = 9;
  typedef enum logic [3:0] {IDLE, W_RD, W_WR, CLR, P_RD, FEED, R_REQ, R_CAP, WR, DONE} state_t;
endpackage

// File: rtl/conv_dma_agu.sv
// conv_dma_agu: word-stepped base + counter address adders for weight, source and destination streams
module conv_dma_agu #(
  parameter int ADDR_W = 32,
  parameter int CNT_W = 16
) (
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [3:0]        wcnt,
  input  logic [CNT_W-1:0]  pcnt,
  input  logic [CNT_W-1:0]  rcnt,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr
);
  assign wgt_addr = wgt_base + ADDR_W'({wcnt, 2'b00});
  assign src_addr = src_base + ADDR_W'({pcnt, 2'b00});
  assign dst_addr = dst_base + ADDR_W'({rcnt, 2'b00});
endmodule

// File: rtl/conv_dma.sv
// conv_dma: loads weights, clears and streams pixels through the conv accelerator, storing results; define CONV_DMA_VALID_ONLY_EN to keep only full-window results
module conv_dma
  import conv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IMG_WIDTH = 128,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  pix_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        acc_addr,
  output logic              acc_en,
  output logic              acc_we,
  output logic [31:0]       acc_din,
  input  logic [31:0]       acc_dout
);
`ifdef CONV_DMA_VALID_ONLY_EN
  localparam bit VALID_ONLY = 1'b1;
`else
  localparam bit VALID_ONLY = 1'b0;
`endif
  state_t state;
  logic [3:0] wcnt;
  logic [CNT_W-1:0] pcnt, rcnt, pix_q;
  logic [ADDR_W-1:0] wgt_q, src_q, dst_q, wgt_addr, src_addr, dst_addr;
  logic [31:0] res_q;
  logic wr_en;
  assign wr_en = !VALID_ONLY || int'(pcnt) >= 2 * IMG_WIDTH + 3;
  conv_dma_agu #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_agu (
    .wgt_base(wgt_q),
    .src_base(src_q),
    .dst_base(dst_q),
    .wcnt(wcnt),
    .pcnt(pcnt),
    .rcnt(rcnt),
    .wgt_addr(wgt_addr),
    .src_addr(src_addr),
    .dst_addr(dst_addr)
  );
  // sequencer: weight load, clear, then read/feed/request/capture/write per pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
      pcnt <= '0;
      rcnt <= '0;
      pix_q <= '0;
      wgt_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= W_RD;
          wcnt <= '0;
          pcnt <= '0;
          rcnt <= '0;
          pix_q <= pix_count;
          wgt_q <= wgt_base;
          src_q <= src_base;
          dst_q <= dst_base;
        end
        W_RD: state <= W_WR;
        W_WR: if (wcnt == 4'(NUM_W - 1)) state <= CLR;
        else begin
          wcnt <= wcnt + 4'd1;
          state <= W_RD;
        end
        CLR: state <= pix_q == '0 ? DONE : P_RD;
        P_RD: state <= FEED;
        FEED: state <= R_REQ;
        R_REQ: state <= R_CAP;
        R_CAP: begin
          res_q <= acc_dout;
          state <= WR;
        end
        WR: begin
          if (wr_en) rcnt <= rcnt + 1'b1;
          pcnt <= pcnt + 1'b1;
          state <= pcnt == pix_q - 1'b1 ? DONE : P_RD;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // bus strobes, addresses and data decoded from the registered state and counters
  always_comb begin
    busy = state != IDLE && state != DONE;
    done = state == DONE;
    mem_re = state == W_RD || state == P_RD;
    mem_we = state == WR && wr_en;
    mem_addr = state == W_RD ? wgt_addr : state == P_RD ? src_addr : mem_we ? dst_addr : '0;
    mem_wdata = mem_we ? res_q : '0;
    acc_en = state inside {W_WR, CLR, FEED, R_REQ, R_CAP};
    acc_we = state inside {W_WR, CLR, FEED};
    acc_addr = state == W_WR ? ADDR_W0 + wcnt : state == CLR ? ADDR_CLR : state == R_REQ ? ADDR_RES : ADDR_PIX;
    acc_din = state == W_WR || state == FEED ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_conv_dma.sv
// tb_conv_dma: scoreboard bench with memory and accelerator models around conv_dma
module tb_conv_dma;
  localparam int AW = 32, IW = 4, CW = 16, NT = 2 * IW + 3;
`ifdef CONV_DMA_VALID_ONLY_EN
  localparam bit VO = 1'b1;
`else
  localparam bit VO = 1'b0;
`endif
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic cd;} ev_t;
  logic clk = 0, rst = 1, start = 0;
  logic [AW-1:0] wgt_base = 0, src_base = 0, dst_base = 0, mem_addr;
  logic [CW-1:0] pix_count = 0;
  logic busy, done, mem_re, mem_we, acc_en, acc_we;
  logic [31:0] mem_rdata = 0, mem_wdata, acc_din, acc_dout = 0;
  logic [3:0] acc_addr;
  int checks = 0, errs = 0, ndone = 0;
  bit ign = 0, prev_rreq = 0;
  ev_t rdq[$], accq[$], wrq[$];
  logic [31:0] mem [4096];
  logic [31:0] aw [9];
  logic [31:0] win [NT];
  logic [31:0] ares = 0;
  logic [31:0] wv [9];
  logic [31:0] pv [64];

  always #5 clk = ~clk;

  conv_dma #(.ADDR_W(AW), .IMG_WIDTH(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .wgt_base(wgt_base), .src_base(src_base),
    .dst_base(dst_base), .pix_count(pix_count), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .acc_addr(acc_addr), .acc_en(acc_en), .acc_we(acc_we),
    .acc_din(acc_din), .acc_dout(acc_dout)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errs++;
    $display("FAIL %s unexpected event, nothing queued at %0t", nm, $time);
  endtask

  function automatic ev_t mk(input logic [31:0] a, input logic [31:0] d, input logic cd);
    ev_t e;
    e.a = a;
    e.d = d;
    e.cd = cd;
    return e;
  endfunction

  // word memory, one-cycle read latency
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr[13:2]];

  // accelerator: 3x3 window over a line buffer, registers the pre-shift sum on each pixel write
  function automatic logic [31:0] wsum();
    logic [31:0] s = 0;
    for (int t = 0; t < 9; t++) s += aw[t] * win[(t / 3) * IW + t % 3];
    return s;
  endfunction

  always @(posedge clk) begin
    if (acc_en && acc_we) begin
      if (acc_addr == 4'd0) begin
        ares <= wsum();
        for (int i = NT - 1; i > 0; i--) win[i] <= win[i-1];
        win[0] <= acc_din;
      end else if (acc_addr == 4'd2) begin
        for (int i = 0; i < NT; i++) win[i] <= '0;
      end else if (acc_addr >= 4'd3 && acc_addr <= 4'd11) begin
        aw[int'(acc_addr) - 3] <= acc_din;
      end
    end
    if (acc_en && !acc_we && acc_addr == 4'd1) acc_dout <= ares;
  end

  // expected result after feeding pixel k: weighted 3x3 window of the pixels before it
  function automatic logic [31:0] ref_res(input int k);
    logic [31:0] s = 0;
    for (int t = 0; t < 9; t++) begin
      int j = k - 1 - ((t / 3) * IW + t % 3);
      if (j >= 0) s += wv[t] * pv[j];
    end
    return s;
  endfunction

  // monitor: bus rules every cycle, scoreboard pops on every DUT transaction
  always @(negedge clk) begin
    ev_t e;
    if (rst) prev_rreq = 0;
    else begin
      chk("re_we_overlap", {mem_re, mem_we} == 2'b11, 0);
      chk("acc_en_idle", !busy && acc_en, 0);
      if (prev_rreq) chk("capture_cycle", {acc_en, acc_we, acc_addr}, {1'b1, 1'b0, 4'd0});
      prev_rreq = acc_en && !acc_we && acc_addr == 4'd1;
      if (done) ndone++;
      if (!ign && mem_re) begin
        if (rdq.size() == 0) miss("mem_read");
        else begin
          e = rdq.pop_front();
          chk("rd_addr", mem_addr, e.a);
        end
      end
      if (!ign && mem_we) begin
        if (wrq.size() == 0) miss("mem_write");
        else begin
          e = wrq.pop_front();
          chk("wr_addr", mem_addr, e.a);
          chk("wr_data", mem_wdata, e.d);
        end
      end
      if (!ign && acc_en && acc_we) begin
        if (accq.size() == 0) miss("acc_write");
        else begin
          e = accq.pop_front();
          chk("acc_addr", acc_addr, e.a);
          if (e.cd) chk("acc_din", acc_din, e.d);
        end
      end
    end
  end

  task automatic load(input logic [31:0] wb, input logic [31:0] sb, input logic [31:0] db, input int n);
    int j = 0;
    rdq.delete();
    accq.delete();
    wrq.delete();
    for (int i = 0; i < 9; i++) begin
      mem[12'((wb + 32'(4 * i)) >> 2)] = wv[i];
      rdq.push_back(mk(wb + 32'(4 * i), 0, 0));
      accq.push_back(mk(32'(3 + i), wv[i], 1));
    end
    accq.push_back(mk(2, 0, 0));
    for (int k = 0; k < n; k++) begin
      mem[12'((sb + 32'(4 * k)) >> 2)] = pv[k];
      rdq.push_back(mk(sb + 32'(4 * k), 0, 0));
      accq.push_back(mk(0, pv[k], 1));
      if (!VO || k >= NT) begin
        wrq.push_back(mk(db + 32'(4 * j), ref_res(k), 1));
        j++;
      end
    end
    @(posedge clk);
    #1;
    wgt_base = wb;
    src_base = sb;
    dst_base = db;
    pix_count = CW'(n);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic run(input logic [31:0] wb, input logic [31:0] sb, input logic [31:0] db, input int n, input bit repulse);
    int cyc = 0;
    bit got = 0;
    ndone = 0;
    load(wb, sb, db, n);
    while (!got && cyc < 40 + 5 * n) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (done) got = 1;
      if (repulse && cyc == 5) begin
        wgt_base = 32'h300;
        src_base = 32'h2000;
        dst_base = 32'h9000;
        pix_count = 7;
        start = 1;
      end
      if (repulse && cyc == 6) start = 0;
    end
    chk("done_seen", got, 1);
    if (got) chk("done_cycle", cyc, 20 + 5 * n);
    repeat (3) @(negedge clk);
    chk("done_pulses", ndone, 1);
    chk("busy_idle", busy, 0);
    chk("reads_left", rdq.size(), 0);
    chk("acc_left", accq.size(), 0);
    chk("writes_left", wrq.size(), 0);
  endtask

  initial begin
    bit seen = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 0;
    for (int i = 0; i < NT; i++) win[i] = 0;
    for (int i = 0; i < 9; i++) aw[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {busy, done, mem_re, mem_we, acc_en, acc_we}, 0);
    chk("reset_addr", {mem_addr, 28'd0, acc_addr}, 0);
    chk("reset_data", {mem_wdata, acc_din}, 0);
    rst = 0;
    for (int i = 0; i < 9; i++) wv[i] = i == 4 ? 1 : 0;
    for (int k = 0; k < 64; k++) pv[k] = 32'(k + 1);
    run(32'h100, 32'h1000, 32'h8000, 16, 0);
    run(32'h100, 32'h1000, 32'h8000, 0, 0);
    for (int i = 0; i < 9; i++) wv[i] = 32'(i + 2);
    run(32'h140, 32'h1100, 32'h8800, 12, 1);
    ign = 1;
    load(32'h100, 32'h1000, 32'h8000, 8);
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      seen = acc_en && acc_we && acc_addr == 4'd0;
    end
    chk("feed_seen", seen, 1);
    ndone = 0;
    rst = 1;
    @(negedge clk);
    chk("rst_strobes", {busy, done, mem_re, mem_we, acc_en, acc_we}, 0);
    rst = 0;
    ign = 0;
    repeat (3) @(negedge clk);
    chk("rst_no_done", ndone, 0);
    run(32'h100, 32'h1000, 32'h8000, 3, 0);
    run(32'hFFFF_FFF0, 32'h1000, 32'hFFFF_FFF8, 4, 0);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 9; i++) wv[i] = $urandom_range(0, 15);
      for (int k = 0; k < 64; k++) pv[k] = $urandom;
      run(32'h100 + 32'($urandom_range(0, 15) * 4), 32'h1000 + 32'($urandom_range(0, 31) * 4),
          {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom_range(0, 24), r == 2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
